// File: rtl/uart_cmd_sender_if.sv
// uart_cmd_sender_if: command request / completion bundle.
// master = command issuer, slave = uart_cmd_sender.
interface uart_cmd_sender_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_mask;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  ack_byte;
  logic        stray;

  modport master (
    output cmd_valid,
    output cmd_opcode,
    output cmd_mask,
    input  cmd_ready,
    input  done,
    input  status,
    input  ack_byte,
    input  stray
  );

  modport slave (
    input  cmd_valid,
    input  cmd_opcode,
    input  cmd_mask,
    output cmd_ready,
    output done,
    output status,
    output ack_byte,
    output stray
  );
endinterface

// File: rtl/uart_cmd_sender.sv
// uart_cmd_sender: sends a command frame on a tx byte
// port and checks the ack byte returned on an rx port.
// Ports: clk, reset_n (async, active low);
//   cmd  : request/completion bundle (slave side);
//   tx_* : Din/Send/Sent handshake to the tx block;
//   rx_* : Receive/Dout/Received handshake to the rx block.
// status: 0=OK, 1=BAD_ACK, 2=TIMEOUT.
module uart_cmd_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_cmd_sender_if.slave cmd,
  output logic [7:0]       tx_din,
  output logic             tx_send,
  input  logic             tx_sent,
  input  logic             rx_receive,
  input  logic [7:0]       rx_dout,
  output logic             rx_received
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_BAD = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  localparam logic [7:0] OP_PSEL = 8'h39;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    SENT_LOW,
    WAIT_ACK,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    opc_q, opc_d;
  logic [31:0]   mask_q, mask_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_din_q, tx_din_d;
  logic          rxr_q, rxr_d;
  logic          stray_q, stray_d;
  logic [1:0]    status_q, status_d;
  logic [7:0]    ack_q, ack_d;

  logic       has_ack;
  logic [7:0] exp_ack;
  logic [2:0] last_idx;
  logic [2:0] idx_nx;
  logic [7:0] next_byte;

  // 0x30..0x39 all answer with opcode+0x11
  // (0x39 -> 0x4A); anything else is silent.
  assign has_ack  = (opc_q >= 8'h30) &&
                    (opc_q <= 8'h39);
  assign exp_ack  = opc_q + 8'h11;
  assign last_idx = (opc_q == OP_PSEL) ?
                    3'd4 : 3'd0;
  assign idx_nx   = idx_q + 3'd1;

  // Mask goes out most significant byte first.
  always_comb begin
    next_byte = mask_q[7:0];
    case (idx_nx)
      3'd1:    next_byte = mask_q[31:24];
      3'd2:    next_byte = mask_q[23:16];
      3'd3:    next_byte = mask_q[15:8];
      default: next_byte = mask_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tx_din_d = tx_din_q;
    rxr_d    = 1'b0;
    stray_d  = 1'b0;
    status_d = status_q;
    ack_d    = ack_q;
    unique case (state_q)
      IDLE: begin
        // rxr_q gate: a byte must be seen
        // again after a consume pulse.
        if (rx_receive && !rxr_q) begin
          rxr_d   = 1'b1;
          stray_d = 1'b1;
        end
        if (cmd.cmd_valid) begin
          opc_d    = cmd.cmd_opcode;
          mask_d   = cmd.cmd_mask;
          idx_d    = 3'd0;
          tx_din_d = cmd.cmd_opcode;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_sent) state_d = SENT_LOW;
      end
      SENT_LOW: begin
        if (!tx_sent) begin
          if (idx_q != last_idx) begin
            idx_d    = idx_nx;
            tx_din_d = next_byte;
            state_d  = SEND;
          end else if (has_ack) begin
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            status_d = ST_OK;
            state_d  = FINISH;
          end
        end
      end
      WAIT_ACK: begin
        // A received byte is checked first, so
        // it beats a coincident timeout.
        if (rxr_q) begin
          state_d = FINISH;
        end else if (rx_receive) begin
          rxr_d    = 1'b1;
          ack_d    = rx_dout;
          status_d = (rx_dout == exp_ack) ?
                     ST_OK : ST_BAD;
        end else if (cnt_q == TMO_LAST) begin
          status_d = ST_TMO;
          state_d  = FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      opc_q    <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tx_din_q <= '0;
      rxr_q    <= 1'b0;
      stray_q  <= 1'b0;
      status_q <= ST_OK;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tx_din_q <= tx_din_d;
      rxr_q    <= rxr_d;
      stray_q  <= stray_d;
      status_q <= status_d;
      ack_q    <= ack_d;
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign cmd.done      = (state_q == FINISH);
  assign cmd.status    = status_q;
  assign cmd.ack_byte  = ack_q;
  assign cmd.stray     = stray_q;
  assign tx_din        = tx_din_q;
  assign tx_send       = (state_q == SEND);
  assign rx_received   = rxr_q;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// tb_uart_cmd_sender: randomized bench with tx/rx
// byte-port models and a frame/ack reference model.
module tb_uart_cmd_sender;

  localparam int unsigned TMO = 50;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_din;
  logic       tx_send;
  logic       tx_sent;
  logic       rx_receive;
  logic [7:0] rx_dout;
  logic       rx_received;

  uart_cmd_sender_if cif ();

  uart_cmd_sender #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (cif.slave),
    .tx_din     (tx_din),
    .tx_send    (tx_send),
    .tx_sent    (tx_sent),
    .rx_receive (rx_receive),
    .rx_dout    (rx_dout),
    .rx_received(rx_received)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // tx port model
  logic [7:0] byte_q[$];
  int drops = 0;
  int last_drop_cyc = 0;
  int tx_delay = 0;
  int tx_unstable = 0;

  initial begin
    int ph;
    int cnt;
    logic [7:0] held;
    ph = 0;
    cnt = 0;
    held = '0;
    tx_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        ph = 0;
        tx_sent = 1'b0;
      end else if (ph == 0) begin
        if (tx_send === 1'b1) begin
          byte_q.push_back(tx_din);
          held = tx_din;
          cnt = (tx_delay > 0) ? tx_delay :
                int'($urandom_range(1, 6));
          ph = 1;
        end
      end else if (ph == 1) begin
        if (tx_send !== 1'b1 || tx_din !== held)
          tx_unstable++;
        cnt--;
        if (cnt <= 0) begin
          tx_sent = 1'b1;
          ph = 2;
        end
      end else begin
        if (tx_din !== held) tx_unstable++;
        if (tx_send !== 1'b1) begin
          tx_sent = 1'b0;
          drops++;
          last_drop_cyc = cyc;
          ph = 0;
        end
      end
    end
  end

  // output monitor
  int done_cnt = 0;
  int rxr_cnt = 0;
  int stray_cnt = 0;
  int rxr_double = 0;
  int ready_in_done = 0;

  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cif.done === 1'b1) begin
        done_cnt++;
        if (cif.cmd_ready !== 1'b0)
          ready_in_done++;
      end
      if (rx_received === 1'b1) begin
        rxr_cnt++;
        if (prev) rxr_double++;
      end
      prev = (rx_received === 1'b1);
      if (cif.stray === 1'b1) stray_cnt++;
    end
  end

  // reference model
  logic [7:0] exp_q[$];
  logic [7:0] model_ack = 8'h00;

  function automatic int exp_ack(
    input logic [7:0] op
  );
    if (op >= 8'h30 && op <= 8'h39)
      return int'(op) + 'h11;
    return -1;
  endfunction

  task automatic build_frame(
    input logic [7:0]  op,
    input logic [31:0] mask
  );
    exp_q.delete();
    exp_q.push_back(op);
    if (op == 8'h39)
      for (int i = 3; i >= 0; i--)
        exp_q.push_back(mask[8*i +: 8]);
  endtask

  // observations of the last command
  bit         o_got;
  int         o_done_cyc;
  int         o_entry_cyc;
  int         o_present_cyc;
  logic [1:0] o_status;
  logic [7:0] o_ack;
  int         o_rxr;
  int         o_stray;
  logic [7:0] o_bytes[$];

  function automatic bit frame_matches();
    if (o_bytes.size() != exp_q.size())
      return 1'b0;
    foreach (exp_q[i])
      if (o_bytes[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rx_present(input logic [7:0] b);
    bit got;
    got = 1'b0;
    rx_dout = b;
    rx_receive = 1'b1;
    o_present_cyc = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_received === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    rx_receive = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rx_consume got 0 want 1");
    end
  endtask

  task automatic run_cmd(
    input logic [7:0]  op,
    input logic [31:0] mask,
    input bit          reply,
    input logic [7:0]  rb,
    input bit          after_wait,
    input int          delay
  );
    int b0, d0, r0, s0, len;
    b0 = byte_q.size();
    d0 = drops;
    r0 = rxr_cnt;
    s0 = stray_cnt;
    len = (op == 8'h39) ? 5 : 1;
    o_got = 1'b0;
    o_entry_cyc = -1;
    o_present_cyc = -1;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (cif.cmd_ready === 1'b1) break;
      @(negedge clk);
    end
    cif.cmd_valid = 1'b1;
    cif.cmd_opcode = op;
    cif.cmd_mask = mask;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          if (cif.done === 1'b1) begin
            o_got = 1'b1;
            o_done_cyc = cyc;
            o_status = cif.status;
            o_ack = cif.ack_byte;
            break;
          end
          @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 3000; i++) begin
          if (after_wait ? (drops - d0 >= len) :
              (byte_q.size() - b0 >= len)) break;
          @(negedge clk);
        end
        o_entry_cyc = last_drop_cyc + 1;
        if (reply) begin
          repeat (delay) @(negedge clk);
          rx_present(rb);
        end
      end
    join
    o_bytes.delete();
    for (int i = b0; i < byte_q.size(); i++)
      o_bytes.push_back(byte_q[i]);
    o_rxr = rxr_cnt - r0;
    o_stray = stray_cnt - s0;
  endtask

  task automatic test_reset();
    checks++;
    if (cif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1",
               cif.cmd_ready);
    end
    checks++;
    if (tx_send !== 1'b0 || tx_din !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx got %b/%h want 0/00",
               tx_send, tx_din);
    end
    checks++;
    if (rx_received !== 1'b0 ||
        cif.done !== 1'b0 ||
        cif.stray !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses got %b%b%b want 000",
               rx_received, cif.done, cif.stray);
    end
    checks++;
    if (cif.status !== 2'd0 ||
        cif.ack_byte !== 8'h00) begin
      errors++;
      $display("FAIL rst_stat got %0d/%h want 0/00",
               cif.status, cif.ack_byte);
    end
  endtask

  task automatic test_single_ok();
    tx_delay = 10;
    build_frame(8'h30, 32'h0);
    run_cmd(8'h30, 32'h0, 1'b1, 8'h41, 1'b1, 3);
    model_ack = 8'h41;
    checks++;
    if (!o_got) begin
      errors++;
      $display("FAIL op30_done got 0 want 1");
    end
    checks++;
    if (!frame_matches()) begin
      errors++;
      $display("FAIL op30_frame got %0d bytes want 1",
               o_bytes.size());
    end
    checks++;
    if (o_status !== 2'd0 || o_ack !== 8'h41) begin
      errors++;
      $display("FAIL op30_stat got %0d/%h want 0/41",
               o_status, o_ack);
    end
    checks++;
    if (o_rxr !== 1) begin
      errors++;
      $display("FAIL op30_rxr got %0d want 1", o_rxr);
    end
  endtask

  task automatic test_port_select();
    tx_delay = 0;
    build_frame(8'h39, 32'hDEADBEEF);
    run_cmd(8'h39, 32'hDEADBEEF, 1'b1, 8'h4A,
            1'b1, 2);
    model_ack = 8'h4A;
    checks++;
    if (!frame_matches()) begin
      errors++;
      $display("FAIL psel_frame got %0d bytes want 5",
               o_bytes.size());
    end
    checks++;
    if (!o_got || o_status !== 2'd0 ||
        o_ack !== 8'h4A) begin
      errors++;
      $display("FAIL psel_stat got %0d/%h want 0/4a",
               o_status, o_ack);
    end
  endtask

  task automatic test_bad_ack();
    build_frame(8'h32, 32'h0);
    run_cmd(8'h32, 32'h0, 1'b1, 8'h44, 1'b1, 1);
    model_ack = 8'h44;
    checks++;
    if (!o_got || o_status !== 2'd1 ||
        o_ack !== 8'h44) begin
      errors++;
      $display("FAIL bad_ack got %0d/%h want 1/44",
               o_status, o_ack);
    end
  endtask

  task automatic test_timeout();
    int lat;
    build_frame(8'h33, 32'h0);
    run_cmd(8'h33, 32'h0, 1'b0, 8'h00, 1'b1, 0);
    lat = o_done_cyc - o_entry_cyc;
    checks++;
    if (!o_got || o_status !== 2'd2) begin
      errors++;
      $display("FAIL tmo_stat got %0d want 2",
               o_status);
    end
    checks++;
    if (lat < int'(TMO) - 1 || lat > int'(TMO) + 1)
    begin
      errors++;
      $display("FAIL tmo_lat got %0d want %0d",
               lat, TMO);
    end
    checks++;
    if (o_ack !== model_ack || o_rxr !== 0) begin
      errors++;
      $display("FAIL tmo_ack got %h/%0d want %h/0",
               o_ack, o_rxr, model_ack);
    end
  endtask

  task automatic test_no_ack_and_stray();
    int s0, r0, dn0;
    build_frame(8'h40, 32'h0);
    run_cmd(8'h40, 32'h0, 1'b0, 8'h00, 1'b0, 0);
    checks++;
    if (!o_got || o_status !== 2'd0 ||
        o_rxr !== 0 || !frame_matches()) begin
      errors++;
      $display("FAIL op40 got st%0d rxr%0d want 0/0",
               o_status, o_rxr);
    end
    repeat (2) @(negedge clk);
    s0 = stray_cnt;
    r0 = rxr_cnt;
    dn0 = done_cnt;
    rx_present(8'h55);
    repeat (3) @(negedge clk);
    checks++;
    if (stray_cnt - s0 !== 1 ||
        rxr_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL stray got %0d/%0d want 1/1",
               stray_cnt - s0, rxr_cnt - r0);
    end
    checks++;
    if (cif.ack_byte !== model_ack ||
        done_cnt != dn0) begin
      errors++;
      $display("FAIL stray_ack got %h want %h",
               cif.ack_byte, model_ack);
    end
  endtask

  task automatic test_ack_latency();
    int lat;
    run_cmd(8'h35, 32'h0, 1'b1, 8'h46, 1'b1, 5);
    model_ack = 8'h46;
    lat = o_done_cyc - o_present_cyc;
    checks++;
    if (!o_got || lat !== 2) begin
      errors++;
      $display("FAIL ack_lat got %0d want 2", lat);
    end
  endtask

  task automatic test_early_reply();
    build_frame(8'h37, 32'h0);
    run_cmd(8'h37, 32'h0, 1'b1, 8'h48, 1'b0, 0);
    model_ack = 8'h48;
    checks++;
    if (!o_got || o_status !== 2'd0 ||
        o_ack !== 8'h48 || o_rxr !== 1) begin
      errors++;
      $display("FAIL early got %0d/%h want 0/48",
               o_status, o_ack);
    end
  endtask

  task automatic test_reset_mid_cmd();
    int b0, dn0;
    tx_delay = 4;
    b0 = byte_q.size();
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_opcode = 8'h39;
    cif.cmd_mask = $urandom;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (byte_q.size() - b0 >= 3) break;
      @(negedge clk);
    end
    dn0 = done_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_send !== 1'b0 ||
        cif.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got %b/%b want 0/1",
               tx_send, cif.cmd_ready);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_ack = 8'h00;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== dn0 ||
        cif.ack_byte !== model_ack) begin
      errors++;
      $display("FAIL mid_rst_done got %0d want 0",
               done_cnt - dn0);
    end
    tx_delay = 0;
    build_frame(8'h31, 32'h0);
    run_cmd(8'h31, 32'h0, 1'b1, 8'h42, 1'b1, 2);
    model_ack = 8'h42;
    checks++;
    if (!o_got || o_status !== 2'd0 ||
        o_ack !== 8'h42 || !frame_matches()) begin
      errors++;
      $display("FAIL post_rst got %0d/%h want 0/42",
               o_status, o_ack);
    end
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [31:0] mask;
    logic [7:0]  rb;
    logic [1:0]  est;
    int ea, mode, erxr;
    bit aw;
    tx_delay = 0;
    for (int n = 0; n < 25; n++) begin
      op = ($urandom_range(0, 9) < 8) ?
           8'($urandom_range(8'h30, 8'h40)) :
           8'($urandom);
      mask = $urandom;
      ea = exp_ack(op);
      mode = (ea < 0) ? 0 : int'($urandom_range(0, 2));
      rb = (mode == 1) ? 8'(ea) : 8'($urandom);
      aw = 1'($urandom_range(0, 1));
      build_frame(op, mask);
      run_cmd(op, mask, mode != 0, rb, aw,
              int'($urandom_range(1, 8)));
      if (ea < 0) est = 2'd0;
      else if (mode == 0) est = 2'd2;
      else est = (rb == 8'(ea)) ? 2'd0 : 2'd1;
      erxr = (ea >= 0 && mode != 0) ? 1 : 0;
      if (erxr == 1) model_ack = rb;
      checks++;
      if (!o_got || !frame_matches()) begin
        errors++;
        $display("FAIL rnd_frame op %h got %0d want %0d",
                 op, o_bytes.size(), exp_q.size());
      end
      checks++;
      if (o_status !== est || o_ack !== model_ack) begin
        errors++;
        $display("FAIL rnd_stat op %h got %0d/%h want %0d/%h",
                 op, o_status, o_ack, est, model_ack);
      end
      checks++;
      if (o_rxr !== erxr || o_stray !== 0) begin
        errors++;
        $display("FAIL rnd_rxr op %h got %0d/%0d want %0d/0",
                 op, o_rxr, o_stray, erxr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dcyc[2];
    int n;
    bit chk_next;
    logic rdy_after;
    tx_delay = 2;
    n = 0;
    chk_next = 1'b0;
    rdy_after = 1'b0;
    dcyc[0] = 0;
    dcyc[1] = 0;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_opcode = 8'h40;
    cif.cmd_mask = 32'h0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (chk_next) begin
        rdy_after = cif.cmd_ready;
        chk_next = 1'b0;
      end
      if (cif.done === 1'b1) begin
        dcyc[n] = cyc;
        n++;
        if (n == 1) chk_next = 1'b1;
        if (n == 2) break;
      end
    end
    cif.cmd_valid = 1'b0;
    checks++;
    if (n !== 2 || dcyc[1] - dcyc[0] !== 6) begin
      errors++;
      $display("FAIL b2b_gap got %0d want 6",
               dcyc[1] - dcyc[0]);
    end
    checks++;
    if (rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b want 1",
               rdy_after);
    end
    checks++;
    if (ready_in_done !== 0 || rxr_double !== 0 ||
        tx_unstable !== 0) begin
      errors++;
      $display("FAIL protocol got %0d/%0d/%0d want 0/0/0",
               ready_in_done, rxr_double, tx_unstable);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_opcode = 8'h00;
    cif.cmd_mask = 32'h0;
    rx_receive = 1'b0;
    rx_dout = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_single_ok();
    test_port_select();
    test_bad_ack();
    test_timeout();
    test_no_ack_and_stray();
    test_ack_latency();
    test_early_reply();
    test_reset_mid_cmd();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_sender.md
Name: uart_cmd_sender

Overview:
- Initiator end of the UART command/ack protocol: turns a command request into a byte sequence on a `tx` instance and checks the ack character returned through an `rx` instance.
- Used in loopback self-test designs and as the host-side driver in block-level benches for the command decoder.
- Handles single-byte opcodes, the port-select frame (opcode 0x39 plus a 4-byte mask) and the silent reset opcode.
- Reports per-command completion status: OK, bad ack or timeout.

Parameters:
TIMEOUT_CYCLES, 2_000_000, clk cycles to wait for an ack byte after the last byte is sent; counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request; accepted when cmd_valid && cmd_ready
cmd_ready  output  1  high only in IDLE
cmd_opcode  input  8  command byte (0x30-0x40 defined)
cmd_mask  input  32  port mask, used only when cmd_opcode==0x39
tx_din  output  8  byte to `tx` Din
tx_send  output  1  to `tx` Send
tx_sent  input  1  from `tx` Sent
rx_receive  input  1  from `rx` Receive (byte available)
rx_dout  input  8  from `rx` Dout
rx_received  output  1  to `rx` Received (consume pulse)
done  output  1  one-cycle pulse at command completion
status  output  2  0=OK, 1=BAD_ACK, 2=TIMEOUT; valid with done, held until next done
ack_byte  output  8  last byte consumed in WAIT_ACK, held
stray  output  1  one-cycle pulse when a byte is consumed while IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; cmd_ready=1; tx_send=0, tx_din=0, rx_received=0, done=0, status=0, ack_byte=0, stray=0; byte index and timeout counter cleared. Reset mid-command abandons it; no done is produced.
- Accept in IDLE:
  - Latch opcode and mask; cmd_ready drops the next cycle.
  - Frame length: 5 bytes for 0x39 (opcode, then mask[31:24], [23:16], [15:8], [7:0]); 1 byte otherwise.
- Expected ack:
  - 0x30..0x38 -> opcode+0x11 (0x41..0x49).
  - 0x39 -> 0x4A after the 4th mask byte.
  - 0x40 and every other value -> none.
- States:
  - IDLE: on accept -> SEND.
  - SEND: tx_din=current byte, tx_send=1 held until tx_sent=1 -> SENT_LOW.
  - SENT_LOW: tx_send=0; wait for tx_sent=0. Then: if more bytes, index+1 -> SEND; else if an ack is expected -> WAIT_ACK; else -> FINISH with status OK.
  - WAIT_ACK: counter increments each cycle.
    - On rx_receive=1: pulse rx_received for one cycle, latch ack_byte=rx_dout, status = OK if equal to expected, else BAD_ACK -> FINISH.
    - If the counter reaches TIMEOUT_CYCLES with no byte: status=TIMEOUT -> FINISH.
    - If rx_receive and the timeout coincide, the byte wins.
  - FINISH: done=1 for one cycle -> IDLE.
- Rx handling:
  - tx_din is stable for the whole SEND/SENT_LOW interval.
  - Bytes arriving during SEND/SENT_LOW are not consumed; they stay pending and are taken in WAIT_ACK.
  - In IDLE, rx_receive=1 -> rx_received pulse plus stray pulse; ack_byte is unchanged.
  - rx_received is never high two consecutive cycles; the next consume waits for rx_receive to be re-observed after the pulse cycle.
- Latency:
  - cmd accept to first tx_send: 1 cycle.
  - rx_receive in WAIT_ACK to done: 2 cycles (consume cycle, FINISH).
  - cmd_valid in the same cycle as done is not accepted; it is accepted in the following IDLE cycle.
- Timeout counter clears on every entry to WAIT_ACK.

Test Plan:
- Opcode 0x30, tx model asserts tx_sent 10 cycles after tx_send, rx model returns 0x41 -> exactly one byte 0x30 sent, done pulse, status=0, ack_byte=0x41.
- Opcode 0x39, mask 0xDEADBEEF, rx returns 0x4A -> bytes 0x39,0xDE,0xAD,0xBE,0xEF in order, each with the full Send/Sent handshake; status=0.
- Opcode 0x32, rx returns 0x44 -> status=1, ack_byte=0x44.
- Opcode 0x33, TIMEOUT_CYCLES=50, no rx byte -> done exactly 50 cycles after entering WAIT_ACK (within one cycle of that count), status=2.
- Opcode 0x40 -> one byte sent, no rx_received, done with status=0. Then an rx byte 0x55 arrives in IDLE -> stray pulse, rx_received pulse, ack_byte unchanged.
- Opcode 0x39 started, reset_n pulled low during the 3rd byte's SEND -> tx_send=0 immediately, cmd_ready=1, no done; a following 0x31 command completes OK with ack 0x42.
